// File: rtl/score_keeper.sv
// Score accumulator with frame-timed combo multiplier and session high score for the spider-block game.
// Latency: one clk_vga cycle from an input pulse to registered outputs. No backpressure: every pulse is consumed on the edge that samples it.
module score_keeper #(
    parameter int BASE_PTS     = 5,
    parameter int MAX_COMBO    = 4,
    parameter int COMBO_WINDOW = 30,
    parameter int MAX_SCORE    = 9999
) (
    input  logic        clk_vga,
    input  logic        rst_n,
    input  logic        game_start,
    input  logic        game_over,
    input  logic        block_hit,
    input  logic        frame_tick,
    output logic [13:0] score,
    output logic [13:0] high_score,
    output logic [3:0]  combo,
    output logic        playing
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int WIN_W = ($clog2(COMBO_WINDOW + 1) > 6) ? $clog2(COMBO_WINDOW + 1) : 6;
    localparam logic [WIN_W-1:0] WIN_SAT   = WIN_W'(COMBO_WINDOW);
    localparam logic [3:0]       COMBO_MAX = 4'(MAX_COMBO);
    localparam logic [15:0]      SCORE_MAX = 16'(MAX_SCORE);

    state_t           state;
    state_t           state_n;
    logic [WIN_W-1:0] win_cnt;
    logic             start_acc;
    logic             over_acc;
    logic             hit_acc;
    logic [3:0]       combo_n;
    logic [15:0]      sum;
    logic [13:0]      score_n;

    always_ff @(posedge clk_vga) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_acc = 1'b0;
        over_acc  = 1'b0;
        hit_acc   = 1'b0;
        case (state)
            IDLE: begin
                start_acc = game_start;
                if (game_start) state_n = PLAY;
            end
            PLAY: begin
                // game_over wins over a hit on the same edge
                over_acc = game_over;
                hit_acc  = block_hit && !game_over;
                if (game_over) state_n = OVER;
            end
            OVER: begin
                start_acc = game_start;
                if (game_start) state_n = PLAY;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        combo_n = 4'd1;
        if (win_cnt < WIN_SAT) begin
            combo_n = (combo >= COMBO_MAX) ? COMBO_MAX : combo + 4'd1;
        end
        sum     = {2'b00, score} + 16'(BASE_PTS) * {12'd0, combo_n};
        score_n = (sum > SCORE_MAX) ? SCORE_MAX[13:0] : sum[13:0];
    end

    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            score      <= '0;
            high_score <= '0;
            combo      <= '0;
            win_cnt    <= WIN_SAT;
        end else begin
            if (start_acc) begin
                score   <= '0;
                combo   <= '0;
                win_cnt <= WIN_SAT;
            end else if (hit_acc) begin
                // hit is judged on the pre-tick window count; a coincident tick is absorbed
                score   <= score_n;
                combo   <= combo_n;
                win_cnt <= '0;
            end else if (frame_tick && (win_cnt < WIN_SAT)) begin
                win_cnt <= win_cnt + 1'b1;
            end
            if (over_acc && (score > high_score)) begin
                high_score <= score;
            end
        end
    end

    assign playing = (state == PLAY);

endmodule

// File: tb/tb_score_keeper.sv
// Randomized and directed bench for score_keeper; a reference model predicts outputs into a queue
// that an independent monitor drains and compares one cycle after each stimulus edge.
module tb_score_keeper;

    localparam int BASE  = 5;
    localparam int MAXC  = 4;
    localparam int WIN   = 30;
    localparam int MAXS  = 9999;

    logic        clk_vga = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_start = 1'b0;
    logic        game_over = 1'b0;
    logic        block_hit = 1'b0;
    logic        frame_tick = 1'b0;
    logic [13:0] score;
    logic [13:0] high_score;
    logic [3:0]  combo;
    logic        playing;

    score_keeper #(
        .BASE_PTS(BASE), .MAX_COMBO(MAXC), .COMBO_WINDOW(WIN), .MAX_SCORE(MAXS)
    ) dut (
        .clk_vga(clk_vga), .rst_n(rst_n), .game_start(game_start), .game_over(game_over),
        .block_hit(block_hit), .frame_tick(frame_tick), .score(score),
        .high_score(high_score), .combo(combo), .playing(playing)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        int score;
        int hi;
        int combo;
        int playing;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // model: mode 0 = not started, 1 = in a game, 2 = game finished
    int m_mode, m_score, m_hi, m_combo, m_frames;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input bit s, input bit o, input bit h, input bit t, input bit r);
        if (!r) begin
            m_mode = 0; m_score = 0; m_hi = 0; m_combo = 0; m_frames = WIN;
        end else if (m_mode == 1) begin
            if (o) begin
                if (m_score > m_hi) m_hi = m_score;
                m_mode = 2;
                if (t) m_frames++;
            end else if (h) begin
                if (m_frames < WIN) m_combo = (m_combo + 1 > MAXC) ? MAXC : m_combo + 1;
                else                m_combo = 1;
                m_score = m_score + BASE * m_combo;
                if (m_score > MAXS) m_score = MAXS;
                m_frames = 0;
            end else if (t) begin
                m_frames++;
            end
        end else begin
            if (s) begin
                m_mode = 1; m_score = 0; m_combo = 0; m_frames = WIN;
            end else if (t) begin
                m_frames++;
            end
        end
    endtask

    task automatic step(input bit s, input bit o, input bit h, input bit t, input bit r);
        exp_t e;
        @(posedge clk_vga);
        #1;
        game_start = s; game_over = o; block_hit = h; frame_tick = t; rst_n = r;
        model(s, o, h, t, r);
        e.score = m_score; e.hi = m_hi; e.combo = m_combo; e.playing = (m_mode == 1) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 1);
    endtask

    // monitor: the entry queued before an edge describes the state after that edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_vga);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk_vga);
                chk("score", int'(score), e.score);
                chk("high_score", int'(high_score), e.hi);
                chk("combo", int'(combo), e.combo);
                chk("playing", int'(playing), e.playing);
            end
        end
    end

    initial begin : stim
        int budget;
        // reset and first hit
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        // combo build-up, 10 ticks apart, then a 5th hit in window
        step(1, 0, 0, 0, 1);                 // ignored: already playing
        for (int k = 0; k < 5; k++) begin
            ticks(10);
            step(0, 0, 1, 0, 1);
        end
        // game over records high score; game_over ignored while over
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 1);                 // hit while over: ignored
        // new game finishing lower; hit on the game_over edge is dropped
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 1, 1, 0, 1);
        // window boundary: exactly WIN ticks resets combo, WIN-1 extends it
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        ticks(WIN);
        step(0, 0, 1, 0, 1);
        ticks(WIN - 1);
        step(0, 0, 1, 0, 1);
        // hit and tick on the same edge
        ticks(WIN - 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 0, 1);
        // saturation at MAX_SCORE
        for (int k = 0; k < 520; k++) step(0, 0, 1, 0, 1);
        ticks(WIN + 3);
        step(0, 0, 1, 0, 1);
        step(0, 1, 0, 0, 1);
        // reset mid-game, then a hit in IDLE
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 1, 0, 1, 1);
        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1499) != 0);
        end
        step(0, 0, 0, 0, 1);
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk_vga);
            budget--;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        @(negedge clk_vga);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
